// File: rtl/hdr_ram_pkg.sv
// Shared defaults, requester ids and FSM encoding for the HDR pipeline SDRAM arbiter.
package hdr_ram_pkg;

    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 128;
    localparam int NUM_REQ    = 3;

    typedef enum logic [1:0] {
        REQ_CAM = 2'd0,
        REQ_HDR = 2'd1,
        REQ_TM  = 2'd2
    } req_id_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/req_slot.sv
// One-entry holding slot for a single requester: latches a strobe, frees on its
// grant's ack, and flags any strobe that had to be dropped because the slot was full.
module req_slot
    import hdr_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              free,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              overflow
);

    logic load;

    // A slot being freed this cycle can take a new strobe back-to-back.
    assign load = req && (!valid || free);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            addr     <= '0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            if (load) begin
                valid <= 1'b1;
                addr  <= req_addr;
                data  <= req_data;
            end else if (free) begin
                valid <= 1'b0;
            end
            if (req && valid && !free)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one SDRAM controller port between camera writes (fixed top priority) and
// round-robin HDR reads / tone-map writes, with in-order registered read return.
module ram_arbiter
    import hdr_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MAX_RD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_wr_req,
    input  logic [ADDR_W-1:0] cam_wr_addr,
    input  logic [DATA_W-1:0] cam_wr_data,
    output logic              cam_busy,
    input  logic              hdr_rd_req,
    input  logic [ADDR_W-1:0] hdr_rd_addr,
    output logic              hdr_busy,
    output logic              hdr_rd_valid,
    output logic [DATA_W-1:0] hdr_rd_data,
    input  logic              tm_wr_req,
    input  logic [ADDR_W-1:0] tm_wr_addr,
    input  logic [DATA_W-1:0] tm_wr_data,
    output logic              tm_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [2:0]        err_overflow
);

    localparam int CNT_W = $clog2(MAX_RD + 1);

    logic [NUM_REQ-1:0]             strobe, free, slot_valid, ovf, elig;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr, slot_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data, slot_data;

    state_t           state, state_nxt;
    req_id_t          grant, win, rr_last;
    logic             pick, issue_ack, rd_inc, rd_dec;
    logic [CNT_W-1:0] rd_cnt;

    assign strobe   = {tm_wr_req,  hdr_rd_req,      cam_wr_req};
    assign req_addr = {tm_wr_addr, hdr_rd_addr,     cam_wr_addr};
    assign req_data = {tm_wr_data, {DATA_W{1'b0}},  cam_wr_data};

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .req      (strobe[i]),
            .req_addr (req_addr[i]),
            .req_data (req_data[i]),
            .free     (free[i]),
            .valid    (slot_valid[i]),
            .addr     (slot_addr[i]),
            .data     (slot_data[i]),
            .overflow (ovf[i])
        );
    end

    assign cam_busy     = slot_valid[REQ_CAM];
    assign hdr_busy     = slot_valid[REQ_HDR];
    assign tm_busy      = slot_valid[REQ_TM];
    assign err_overflow = ovf;

    assign mem_req   = (state == ST_ISSUE);
    assign issue_ack = (state == ST_ISSUE) && mem_ack;

    always_comb begin
        free = '0;
        if (issue_ack)
            free[grant] = 1'b1;
    end

    // Reads are held back once the controller already has MAX_RD in flight.
    assign elig = {slot_valid[REQ_TM],
                   slot_valid[REQ_HDR] && (rd_cnt < CNT_W'(MAX_RD)),
                   slot_valid[REQ_CAM]};
    assign pick = |elig;

    always_comb begin
        win = REQ_CAM;
        if (elig[REQ_CAM])
            win = REQ_CAM;
        else if (elig[REQ_HDR] && elig[REQ_TM])
            win = (rr_last == REQ_TM) ? REQ_HDR : REQ_TM;
        else if (elig[REQ_HDR])
            win = REQ_HDR;
        else if (elig[REQ_TM])
            win = REQ_TM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick)    state_nxt = ST_ISSUE;
            ST_ISSUE: if (mem_ack) state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // Command fields are captured on the pick and held untouched through ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= REQ_CAM;
            rr_last   <= REQ_TM;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (state == ST_IDLE && pick) begin
            grant     <= win;
            mem_we    <= (win != REQ_HDR);
            mem_addr  <= slot_addr[win];
            mem_wdata <= slot_data[win];
            if (win != REQ_CAM)
                rr_last <= win;
        end
    end

    assign rd_inc = issue_ack && (grant == REQ_HDR);
    assign rd_dec = mem_rd_valid && (rd_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_cnt <= '0;
        else if (rd_inc && !rd_dec)
            rd_cnt <= rd_cnt + CNT_W'(1);
        else if (!rd_inc && rd_dec)
            rd_cnt <= rd_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_rd_valid <= 1'b0;
            hdr_rd_data  <= '0;
        end else begin
            hdr_rd_valid <= mem_rd_valid;
            if (mem_rd_valid)
                hdr_rd_data <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized + directed bench for ram_arbiter: a cycle-level reference model predicts
// commands and read returns into queues that an independent monitor drains and compares.
module tb_ram_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 128;
    localparam int MAX_RD = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cam_wr_req = 1'b0, hdr_rd_req = 1'b0, tm_wr_req = 1'b0;
    logic [ADDR_W-1:0] cam_wr_addr = '0, hdr_rd_addr = '0, tm_wr_addr = '0;
    logic [DATA_W-1:0] cam_wr_data = '0, tm_wr_data = '0;
    logic              cam_busy, hdr_busy, tm_busy;
    logic              hdr_rd_valid;
    logic [DATA_W-1:0] hdr_rd_data;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0, mem_rd_valid = 1'b0;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic [2:0]        err_overflow;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cam_wr_req(cam_wr_req), .cam_wr_addr(cam_wr_addr), .cam_wr_data(cam_wr_data), .cam_busy(cam_busy),
        .hdr_rd_req(hdr_rd_req), .hdr_rd_addr(hdr_rd_addr), .hdr_busy(hdr_busy),
        .hdr_rd_valid(hdr_rd_valid), .hdr_rd_data(hdr_rd_data),
        .tm_wr_req(tm_wr_req), .tm_wr_addr(tm_wr_addr), .tm_wr_data(tm_wr_data), .tm_busy(tm_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    cmd_t              cmd_q[$];
    logic [DATA_W-1:0] rd_q[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic              log_we[$];
    int                n_chk = 0;
    int                n_fail = 0;

    function automatic void chkb(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chkv(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model state: what the registered outputs should be during the current cycle.
    logic [2:0]        m_v = '0, m_ovf = '0;
    logic [ADDR_W-1:0] m_a[3];
    logic [DATA_W-1:0] m_d[3];
    int                m_pend = -1;   // requester on the port, -1 when the port is idle
    int                m_rr = 2;      // last of hdr(1)/tm(2) granted
    int                m_cnt = 0;     // reads the controller still owes us
    logic              m_rdv = 1'b0;

    logic [2:0]        t_rq, t_fr, t_el;
    logic [ADDR_W-1:0] t_ra[3];
    logic [DATA_W-1:0] t_rd[3];
    int                t_w, t_np, t_inc, t_dec;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_v = '0; m_ovf = '0; m_pend = -1; m_rr = 2; m_cnt = 0; m_rdv = 1'b0;
            cmd_q.delete();
            rd_q.delete();
        end else begin
            chkb("cam_busy", cam_busy, m_v[0]);
            chkb("hdr_busy", hdr_busy, m_v[1]);
            chkb("tm_busy", tm_busy, m_v[2]);
            chkv("err_overflow", DATA_W'(err_overflow), DATA_W'(m_ovf));
            chkb("mem_req", mem_req, m_pend >= 0);
            chkb("hdr_rd_valid", hdr_rd_valid, m_rdv);

            t_rq = {tm_wr_req, hdr_rd_req, cam_wr_req};
            t_ra[0] = cam_wr_addr; t_ra[1] = hdr_rd_addr; t_ra[2] = tm_wr_addr;
            t_rd[0] = cam_wr_data; t_rd[1] = '0;          t_rd[2] = tm_wr_data;
            t_fr = '0;
            if (m_pend >= 0 && mem_ack) t_fr[m_pend] = 1'b1;

            t_np = m_pend;
            if (m_pend < 0) begin
                t_el = {m_v[2], m_v[1] && (m_cnt < MAX_RD), m_v[0]};
                t_w = -1;
                if (t_el[0])                t_w = 0;
                else if (t_el[1] && t_el[2]) t_w = (m_rr == 2) ? 1 : 2;
                else if (t_el[1])           t_w = 1;
                else if (t_el[2])           t_w = 2;
                if (t_w >= 0) begin
                    cmd_q.push_back('{we: (t_w != 1), addr: m_a[t_w], data: m_d[t_w]});
                    if (t_w != 0) m_rr = t_w;
                    t_np = t_w;
                end
            end else if (mem_ack) begin
                t_np = -1;
            end

            t_inc = (m_pend == 1 && mem_ack) ? 1 : 0;
            t_dec = (mem_rd_valid && m_cnt > 0) ? 1 : 0;
            m_cnt = m_cnt + t_inc - t_dec;
            m_pend = t_np;

            for (int i = 0; i < 3; i++) begin
                if (t_rq[i]) begin
                    if (!m_v[i] || t_fr[i]) begin
                        m_v[i] = 1'b1; m_a[i] = t_ra[i]; m_d[i] = t_rd[i];
                    end else begin
                        m_ovf[i] = 1'b1;
                    end
                end else if (t_fr[i]) begin
                    m_v[i] = 1'b0;
                end
            end

            if (mem_rd_valid) rd_q.push_back(mem_rd_data);
            m_rdv = mem_rd_valid;
        end
    end

    // Monitor: compares whatever the DUT presents against the predicted queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) begin
                chkb("cmd_predicted", cmd_q.size() != 0, 1'b1);
                if (cmd_q.size() != 0) begin
                    chkb("mem_we", mem_we, cmd_q[0].we);
                    chkv("mem_addr", DATA_W'(mem_addr), DATA_W'(cmd_q[0].addr));
                    if (cmd_q[0].we) chkv("mem_wdata", mem_wdata, cmd_q[0].data);
                    if (mem_ack) begin
                        log_addr.push_back(mem_addr);
                        log_we.push_back(mem_we);
                        void'(cmd_q.pop_front());
                    end
                end
            end
            if (hdr_rd_valid) begin
                chkb("rd_predicted", rd_q.size() != 0, 1'b1);
                if (rd_q.size() != 0) begin
                    chkv("hdr_rd_data", hdr_rd_data, rd_q[0]);
                    void'(rd_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cam_wr_req = 1'b0; hdr_rd_req = 1'b0; tm_wr_req = 1'b0; mem_rd_valid = 1'b0;
    endtask

    task automatic strobe_hdr(input logic [ADDR_W-1:0] a);
        int k = 0;
        @(negedge clk);
        while (hdr_busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chkb("hdr_slot_free", hdr_busy, 1'b0);
        step();
        hdr_rd_req = 1'b1; hdr_rd_addr = a;
        step();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        mem_ack = 1'b1;
        while ((m_v != '0 || m_pend >= 0 || m_cnt > 0) && k < budget) begin
            step();
            mem_rd_valid = (m_cnt > 0);
            mem_rd_data  = rnd_data();
            k++;
        end
        chkb("drain_done", (m_v == '0) && (m_pend < 0) && (m_cnt == 0), 1'b1);
        step();
        step();
    endtask

    logic [ADDR_W-1:0] exp_addr[5];
    logic              exp_we[5];
    logic [DATA_W-1:0] d1, d2;

    initial begin
        repeat (3) @(negedge clk);
        chkb("rst_cam_busy", cam_busy, 1'b0);
        chkb("rst_hdr_busy", hdr_busy, 1'b0);
        chkb("rst_tm_busy", tm_busy, 1'b0);
        chkb("rst_mem_req", mem_req, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chkv("rst_mem_addr", DATA_W'(mem_addr), '0);
        chkv("rst_mem_wdata", mem_wdata, '0);
        chkb("rst_hdr_rd_valid", hdr_rd_valid, 1'b0);
        chkv("rst_hdr_rd_data", hdr_rd_data, '0);
        chkv("rst_err_overflow", DATA_W'(err_overflow), '0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Single camera write: busy in cycles 1-2, one-cycle mem_req in cycle 2.
        mem_ack = 1'b1;
        d1 = rnd_data();
        cam_wr_req = 1'b1; cam_wr_addr = 25'h96000; cam_wr_data = d1;
        @(negedge clk);
        chkb("t1_c0_busy", cam_busy, 1'b0);
        step();
        @(negedge clk);
        chkb("t1_c1_busy", cam_busy, 1'b1);
        chkb("t1_c1_req", mem_req, 1'b0);
        step();
        @(negedge clk);
        chkb("t1_c2_req", mem_req, 1'b1);
        chkb("t1_c2_we", mem_we, 1'b1);
        chkv("t1_c2_addr", DATA_W'(mem_addr), DATA_W'(25'h96000));
        chkv("t1_c2_wdata", mem_wdata, d1);
        chkb("t1_c2_busy", cam_busy, 1'b1);
        step();
        @(negedge clk);
        chkb("t1_c3_req", mem_req, 1'b0);
        chkb("t1_c3_busy", cam_busy, 1'b0);
        repeat (2) step();

        // Simultaneous strobes: cam, hdr, tm; then a fresh hdr+tm pair goes hdr first.
        log_addr.delete(); log_we.delete();
        cam_wr_req = 1'b1; cam_wr_addr = 25'h100; cam_wr_data = rnd_data();
        hdr_rd_req = 1'b1; hdr_rd_addr = 25'h200;
        tm_wr_req  = 1'b1; tm_wr_addr  = 25'h300; tm_wr_data  = rnd_data();
        repeat (10) step();
        hdr_rd_req = 1'b1; hdr_rd_addr = 25'h210;
        tm_wr_req  = 1'b1; tm_wr_addr  = 25'h310; tm_wr_data  = rnd_data();
        repeat (8) step();
        exp_addr = '{25'h100, 25'h200, 25'h300, 25'h210, 25'h310};
        exp_we   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        chkv("t2_grants", DATA_W'(log_addr.size()), DATA_W'(5));
        if (log_addr.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chkv("t2_order_addr", DATA_W'(log_addr[i]), DATA_W'(exp_addr[i]));
                chkb("t2_order_we", log_we[i], exp_we[i]);
            end
        end
        drain(100);

        // Outstanding-read limit: the fifth read waits for a return.
        log_addr.delete(); log_we.delete();
        for (int k = 0; k < 5; k++) strobe_hdr(ADDR_W'(32'h400 + k));
        repeat (6) step();
        @(negedge clk);
        chkb("t3_fifth_held", hdr_busy, 1'b1);
        chkb("t3_no_req", mem_req, 1'b0);
        chkv("t3_reads_issued", DATA_W'(log_addr.size()), DATA_W'(4));
        step();
        mem_rd_valid = 1'b1; mem_rd_data = rnd_data();
        repeat (5) step();
        chkv("t3_fifth_issued", DATA_W'(log_addr.size()), DATA_W'(5));
        chkb("t3_slot_freed", hdr_busy, 1'b0);
        drain(100);

        // Stalled controller: command held stable, second camera strobe overflows.
        mem_ack = 1'b0;
        d1 = rnd_data();
        cam_wr_req = 1'b1; cam_wr_addr = 25'h1234; cam_wr_data = d1;
        repeat (11) step();
        @(negedge clk);
        chkb("t4_req_held", mem_req, 1'b1);
        chkv("t4_addr_held", DATA_W'(mem_addr), DATA_W'(25'h1234));
        chkv("t4_wdata_held", mem_wdata, d1);
        chkv("t4_no_ovf_yet", DATA_W'(err_overflow), '0);
        cam_wr_req = 1'b1; cam_wr_addr = 25'h1235; cam_wr_data = rnd_data();
        step();
        @(negedge clk);
        chkv("t4_ovf_set", DATA_W'(err_overflow), DATA_W'(3'b001));
        mem_ack = 1'b1;
        repeat (4) step();
        chkv("t4_ovf_sticky", DATA_W'(err_overflow), DATA_W'(3'b001));
        chkb("t4_cam_free", cam_busy, 1'b0);

        // Strobe coincident with its own slot's ack reloads without overflow.
        d1 = rnd_data(); d2 = rnd_data();
        tm_wr_req = 1'b1; tm_wr_addr = 25'h500; tm_wr_data = d1;
        step();
        step();
        tm_wr_req = 1'b1; tm_wr_addr = 25'h501; tm_wr_data = d2;
        @(negedge clk);
        chkb("t5_first_req", mem_req, 1'b1);
        chkv("t5_first_addr", DATA_W'(mem_addr), DATA_W'(25'h500));
        step();
        @(negedge clk);
        chkb("t5_busy_kept", tm_busy, 1'b1);
        chkv("t5_no_ovf", DATA_W'(err_overflow), DATA_W'(3'b001));
        step();
        @(negedge clk);
        chkb("t5_second_req", mem_req, 1'b1);
        chkv("t5_second_addr", DATA_W'(mem_addr), DATA_W'(25'h501));
        chkv("t5_second_wdata", mem_wdata, d2);
        repeat (3) step();

        // Asynchronous reset while issuing with two reads outstanding.
        strobe_hdr(25'h600);
        strobe_hdr(25'h601);
        repeat (3) step();
        mem_ack = 1'b0;
        strobe_hdr(25'h602);
        begin
            int k = 0;
            @(negedge clk);
            while (!mem_req && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        chkb("t6_in_issue", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chkb("t6_req_cleared", mem_req, 1'b0);
        chkb("t6_hdr_busy_cleared", hdr_busy, 1'b0);
        chkv("t6_ovf_cleared", DATA_W'(err_overflow), '0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        log_addr.delete(); log_we.delete();
        for (int k = 0; k < 4; k++) strobe_hdr(ADDR_W'(32'h700 + k));
        repeat (4) step();
        chkv("t6_full_credit", DATA_W'(log_addr.size()), DATA_W'(4));
        drain(100);

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            step();
            mem_ack     = ($urandom_range(0, 9) < 7);
            cam_wr_req  = ($urandom_range(0, 9) < 2);
            cam_wr_addr = ADDR_W'($urandom());
            cam_wr_data = rnd_data();
            hdr_rd_req  = ($urandom_range(0, 9) < 3);
            hdr_rd_addr = ADDR_W'($urandom());
            tm_wr_req   = ($urandom_range(0, 9) < 3);
            tm_wr_addr  = ADDR_W'($urandom());
            tm_wr_data  = rnd_data();
            mem_rd_valid = (m_cnt > 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 49) == 0);
            mem_rd_data  = rnd_data();
        end
        step();
        drain(300);
        chkv("end_cmd_q_empty", DATA_W'(cmd_q.size()), '0);
        chkv("end_rd_q_empty", DATA_W'(rd_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
